// File: rtl/lut_burst_reader_if.sv
// rtl/lut_burst_reader_if.sv - request, memory and output-stream signals of the burst reader
interface lut_burst_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [LEN_WIDTH-1:0]  i_len;
    logic                  o_busy;
    logic                  o_done;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output i_start, i_base_addr, i_len, i_mem_rdata, i_ready,
        input  o_busy, o_done, o_mem_addr, o_data, o_valid
    );

    modport slave (
        input  i_start, i_base_addr, i_len, i_mem_rdata, i_ready,
        output o_busy, o_done, o_mem_addr, o_data, o_valid
    );
endinterface

// File: rtl/lut_burst_reader.sv
// rtl/lut_burst_reader.sv - burst read sequencer for registered-address lookup memories
module lut_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    lut_burst_reader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
    logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  rd_idx_q, wr_idx_q;
    logic [1:0]            occ_q;

    logic       pop, push, issue;
    logic [2:0] level;

    assign pop  = (occ_q != 2'd0) && bus.i_ready;
    assign push = inflight_q;
    // Occupancy one cycle ahead, counting the word already requested from memory.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == S_RUN) && (issue_left_q != '0) && (level <= 3'd1);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        issue_left_d = issue_left_q;
        out_left_d   = out_left_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    ptr_d        = bus.i_base_addr;
                    issue_left_d = bus.i_len;
                    out_left_d   = bus.i_len;
                    state_d      = (bus.i_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (issue) begin
                    ptr_d        = ptr_q + ADDR_ONE;
                    issue_left_d = issue_left_q - LEN_ONE;
                end
                if (pop) begin
                    out_left_d = out_left_q - LEN_ONE;
                    if (out_left_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            inflight_q   <= issue;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_idx_q <= 1'b0;
            wr_idx_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_idx_q] <= bus.i_mem_rdata;
                wr_idx_q        <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_done     = (state_q == S_DONE);
    assign bus.o_mem_addr = ptr_q;
    assign bus.o_valid    = (occ_q != 2'd0);
    assign bus.o_data     = buf_q[rd_idx_q];
endmodule

// File: tb/tb_lut_burst_reader.sv
// tb/tb_lut_burst_reader.sv - directed bench for lut_burst_reader
module tb_lut_burst_reader;
    logic clk;
    logic rst_n;

    lut_burst_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .LEN_WIDTH(7)) bus ();

    lut_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .LEN_WIDTH(7)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered address, mem[a] = a.
    always @(posedge clk) bus.i_mem_rdata <= {2'b00, bus.o_mem_addr};

    typedef struct {
        logic [5:0] base;
        logic [6:0] len;
        int         mode;
        logic [7:0] first;
        int         done_cyc;
        int         idle_cyc;
    } vec_t;

    vec_t       vecs [6];
    int         checks;
    int         errors;
    logic [7:0] got [$];
    int         got_cyc [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mode 0: ready held high; mode 1: random ready then stall in cycles 6..10;
    // mode 2: ready high plus extra starts (base 0x20) in cycles 2 and 6.
    task automatic run_burst(input logic [5:0] base, input logic [6:0] len, input int mode,
                             output int done_cyc, output int idle_cyc, output int n_done);
        logic       pv;
        logic [7:0] pd;
        int         occ;
        got.delete();
        got_cyc.delete();
        done_cyc = -1;
        idle_cyc = -1;
        n_done   = 0;
        pv       = 1'b0;
        pd       = '0;
        @(posedge clk); #1;
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        bus.i_len       = len;
        bus.i_ready     = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        if (mode == 2) bus.i_base_addr = 6'h20;
        for (int k = 1; k < 300; k++) begin
            case (mode)
                1: bus.i_ready = (k >= 6 && k <= 10) ? 1'b0 :
                                 (k >= 11) ? 1'b1 : 1'($urandom_range(0, 1));
                2: bus.i_start = (k == 2 || k == 6);
                default: bus.i_ready = 1'b1;
            endcase
            @(negedge clk);
            if (!bus.o_busy && k > 1) begin
                idle_cyc = k;
                break;
            end
            if (bus.o_done) begin
                n_done++;
                done_cyc = k;
                chk("done_with_valid", int'(bus.o_valid), 0);
            end
            if (pv) begin
                chk("stall_valid", int'(bus.o_valid), 1);
                chk("stall_data", int'(bus.o_data), int'(pd));
            end
            occ = int'(dut.occ_q);
            chk("occ_le_2", int'(occ <= 2), 1);
            if (mode == 0 && k <= int'(len))
                chk("mem_addr", int'(bus.o_mem_addr), (int'(base) + k - 1) % 64);
            if (mode == 1 && k >= 11 && got.size() < int'(len))
                chk("no_bubble", int'(bus.o_valid), 1);
            if (bus.o_valid && bus.i_ready) begin
                got.push_back(bus.o_data);
                got_cyc.push_back(k);
            end
            pv = bus.o_valid & ~bus.i_ready;
            pd = bus.o_data;
            @(posedge clk); #1;
        end
        bus.i_start = 1'b0;
        if (idle_cyc < 0) chk("burst_timeout", 0, 1);
    endtask

    int d_cyc, i_cyc, n_dn;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{base: 6'h05, len: 7'd4,  mode: 0, first: 8'h05, done_cyc: 7,  idle_cyc: 8};
        vecs[1] = '{base: 6'h3E, len: 7'd4,  mode: 0, first: 8'h3E, done_cyc: 7,  idle_cyc: 8};
        vecs[2] = '{base: 6'h10, len: 7'd8,  mode: 1, first: 8'h10, done_cyc: -1, idle_cyc: -1};
        vecs[3] = '{base: 6'h00, len: 7'd0,  mode: 0, first: 8'h00, done_cyc: 1,  idle_cyc: 2};
        vecs[4] = '{base: 6'h00, len: 7'd3,  mode: 2, first: 8'h00, done_cyc: 6,  idle_cyc: 7};
        vecs[5] = '{base: 6'h3C, len: 7'd64, mode: 0, first: 8'h3C, done_cyc: 67, idle_cyc: 68};

        rst_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_len       = '0;
        bus.i_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  int'(bus.o_busy), 0);
        chk("rst_done",  int'(bus.o_done), 0);
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_data",  int'(bus.o_data), 0);
        chk("rst_addr",  int'(bus.o_mem_addr), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, d_cyc, i_cyc, n_dn);
            chk("word_count", got.size(), int'(vecs[v].len));
            for (int i = 0; i < got.size(); i++) begin
                chk("word_value", int'(got[i]), (int'(vecs[v].first) + i) % 64);
                if (vecs[v].mode != 1) chk("word_cycle", got_cyc[i], 3 + i);
            end
            chk("done_pulses", n_dn, 1);
            if (vecs[v].done_cyc >= 0) chk("done_cycle", d_cyc, vecs[v].done_cyc);
            if (vecs[v].idle_cyc >= 0) chk("idle_cycle", i_cyc, vecs[v].idle_cyc);
        end

        // Asynchronous reset with two words buffered.
        @(posedge clk); #1;
        bus.i_start     = 1'b1;
        bus.i_base_addr = 6'h00;
        bus.i_len       = 7'd16;
        bus.i_ready     = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", int'(bus.o_valid), 1);
        chk("pre_rst_data",  int'(bus.o_data), 0);
        chk("pre_rst_occ",   int'(dut.occ_q), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bus.o_valid), 0);
        chk("arst_busy",  int'(bus.o_busy), 0);
        chk("arst_addr",  int'(bus.o_mem_addr), 0);
        chk("arst_done",  int'(bus.o_done), 0);
        chk("arst_data",  int'(bus.o_data), 0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        bus.i_ready = 1'b1;
        run_burst(6'h30, 7'd2, 0, d_cyc, i_cyc, n_dn);
        chk("post_rst_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("post_rst_w0", int'(got[0]), 8'h30);
            chk("post_rst_w1", int'(got[1]), 8'h31);
        end
        chk("post_rst_done", d_cyc, 5);
        chk("post_rst_pulses", n_dn, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lut_burst_reader.md
# lut_burst_reader

Client-side read sequencer for the single-port, registered-address lookup memories in the MRELBP datapath. It accepts a burst request (base address, length) and drives the memory address port. The memory's data appears one cycle after the address edge, so the block absorbs that latency and streams the returned words downstream over a valid/ready interface. A 2-entry output buffer gives full throughput and lossless backpressure.

## Interface
- DATA_WIDTH, 8, memory/stream word width
- ADDR_WIDTH, 6, memory address width; memory depth 2**ADDR_WIDTH
- LEN_WIDTH, ADDR_WIDTH+1, burst length width; lengths up to 2**ADDR_WIDTH are legal
- i_clk  in  1  global clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  burst request; sampled only while o_busy=0
- i_base_addr  in  ADDR_WIDTH  first address of burst, sampled with i_start
- i_len  in  LEN_WIDTH  words in burst, sampled with i_start; 0 is legal
- o_busy  out  1  high from the cycle after an accepted start through the DONE cycle
- o_done  out  1  one-cycle pulse when the burst is complete
- o_mem_addr  out  ADDR_WIDTH  read pointer to memory; the memory registers it every edge
- i_mem_rdata  in  DATA_WIDTH  memory data; valid the cycle after the address edge
- o_data  out  DATA_WIDTH  buffer head word
- o_valid  out  1  buffer non-empty
- i_ready  in  1  downstream accept; handshake = o_valid & i_ready

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: on i_start, latch ptr<=i_base_addr, issue_left<=i_len, out_left<=i_len. Go to RUN if i_len!=0, else go to DONE.
  - RUN: go to DONE on the edge where the handshake occurs and out_left==1.
  - DONE: o_done=1; unconditionally go to IDLE.
- i_start during RUN or DONE is ignored; no queueing.
- o_mem_addr = ptr, a register output with no combinational path from inputs.
- Issue rule (combinational): issue = RUN & issue_left!=0 & (occ + inflight − pop) ≤ 1.
  - occ is buffer occupancy, 0..2.
  - inflight is a 1-bit register: 1 if an issue happened on the previous edge.
  - pop = o_valid & i_ready.
- On an issue edge: ptr<=ptr+1, with wrap modulo 2**ADDR_WIDTH (max address is followed by 0). issue_left decrements and inflight<=1. Otherwise inflight<=0.
- When inflight=1, i_mem_rdata is written into the buffer at the end of that cycle. Data returned in non-inflight cycles is ignored.
- Buffer: 2-entry FIFO. Push and pop in the same cycle are allowed at any occupancy reachable under the issue rule. The issue rule guarantees no overflow; overflow is a design error (bench asserts occ ≤ 2).
- out_left decrements on each handshake. Words are delivered in address order, exactly len words, with no duplicates or drops.
- o_data holds the FIFO head and is stable while o_valid=1 and i_ready=0.

## Timing
- Reset values: o_busy=0, o_done=0, o_valid=0, o_data=0, o_mem_addr=0. State IDLE, inflight=0, occ=0, counters 0.
- Reset asserted mid-burst clears everything immediately; outputs take reset values without waiting for a clock edge. Words in flight are discarded.
- Cycle numbering: start accepted at the end of cycle 0.
- Cycle 1: RUN, o_busy=1, o_mem_addr=base, first issue.
- Cycle 2: word 0 on i_mem_rdata, pushed at end of cycle.
- Cycle 3: o_valid=1, o_data=word 0. First-word latency is 3 cycles from the start cycle.
- With i_ready held at 1: one word per cycle, words in cycles 3..N+2, o_done in cycle N+3, o_busy=0 and a new start accepted in cycle N+4.
- len=0: DONE in cycle 1 (o_done=1, o_busy=1), IDLE in cycle 2. No memory issue and no o_valid.
- Backpressure: with i_ready=0, at most 2 words are buffered and issue stops. Issue resumes in the same cycle i_ready returns to 1, so there are no bubbles after the stall.
- o_done is never asserted in the same cycle as o_valid.

## Test plan
Bench memory model: registered address, contents mem[a]=a.
- Basic burst: start base=0x05, len=4, i_ready=1 → o_data 0x05,0x06,0x07,0x08 in cycles 3..6; o_done in cycle 7; o_busy low in cycle 8.
- Wrap: base=0x3E, len=4 → stream 0x3E,0x3F,0x00,0x01; o_mem_addr wraps 0x3F→0x00.
- Backpressure: base=0x10, len=8, i_ready toggled randomly and held low for 5 cycles mid-burst → exactly 0x10..0x17 in order. occ never exceeds 2. o_data stable while stalled. 1 word/cycle after the stall ends.
- Zero length: start len=0 → o_done in cycle 1, o_busy low in cycle 2, o_valid never asserted.
- Start while busy: second i_start (base=0x20) during a len=3 burst from 0x00 → ignored. Only 0x00..0x02 are delivered and a single o_done pulse occurs.
- Reset mid-burst: i_rst_n low asynchronously during a len=16 burst with 2 words buffered → o_valid=0, o_busy=0, o_mem_addr=0 immediately. After release, a new burst from 0x30, len=2, yields 0x30,0x31 only.
